// File: rtl/pc_pkg.sv
// pc_pkg: shared encodings for the program-counter unit.
//   sel_t   : next-PC source codes carried on the 3-bit sel port (5-7 reserved)
//   state_t : run/halt state of the PC unit
package pc_pkg;

   typedef enum logic [2:0] {
      SEL_SEQ    = 3'd0,
      SEL_BRANCH = 3'd1,
      SEL_JALR   = 3'd2,
      SEL_TRAP   = 3'd3,
      SEL_MRET   = 3'd4
   } sel_t;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   localparam logic [2:0] SEL_LAST = 3'd4;

   function automatic logic sel_is_legal(input logic [2:0] code);
      return code <= SEL_LAST;
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc: combinational next-PC target and alignment check.
//   sel        : next-PC source code
//   pc_current : PC of the current instruction
//   imm        : sign-extended immediate offset
//   base       : rs1 value for JALR
//   mtvec      : trap vector
//   mepc       : trap return address
//   target     : computed next PC (additions wrap modulo 2^XLEN)
//   misaligned : target violates IALIGN (only possible when IALIGN=32)
module pc_target_calc
   import pc_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int IALIGN = 32
) (
   input  logic [2:0]      sel,
   input  logic [XLEN-1:0] pc_current,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] base,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic [XLEN-1:0] target,
   output logic            misaligned
);

   localparam logic [XLEN-1:0] CLR_B0   = ~XLEN'(1);
   localparam logic [XLEN-1:0] CLR_B10  = ~XLEN'(3);
   // MRET drops bit1 too only when 32-bit alignment is required.
   localparam logic [XLEN-1:0] MRET_MSK = (IALIGN == 32) ? CLR_B10 : CLR_B0;

   always_comb begin
      target = pc_current + XLEN'(4);
      case (sel)
         SEL_SEQ:    target = pc_current + XLEN'(4);
         SEL_BRANCH: target = pc_current + imm;
         SEL_JALR:   target = (base + imm) & CLR_B0;
         SEL_TRAP:   target = mtvec & CLR_B10;
         SEL_MRET:   target = mepc & MRET_MSK;
         default:    target = pc_current + XLEN'(4);
      endcase
   end

   assign misaligned = (IALIGN == 32) && target[1];

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter register file with run/halt control.
//   clk, rst     : clock and synchronous active-high reset
//   en           : update request (ignored while halted)
//   sel          : next-PC source (see pc_pkg)
//   imm, base    : branch/JALR operands
//   mtvec, mepc  : trap vector and trap return address
//   halt_req     : request halt; resume_req : request resume
//   pc_current   : current PC;  pc_old : PC before the last accepted update
//   pc_plus4     : pc_current + 4 (combinational)
//   exc_misalign : one-cycle pulse when a misaligned target is rejected
//   exc_tval     : rejected target, held until the next pulse
//   halted       : high in HALTED state
//   upd_count    : count of accepted updates (wraps)
module pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              IALIGN       = 32,
   parameter int              CNT_W        = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [2:0]        sel,
   input  logic [XLEN-1:0]   imm,
   input  logic [XLEN-1:0]   base,
   input  logic [XLEN-1:0]   mtvec,
   input  logic [XLEN-1:0]   mepc,
   input  logic              halt_req,
   input  logic              resume_req,
   output logic [XLEN-1:0]   pc_current,
   output logic [XLEN-1:0]   pc_old,
   output logic [XLEN-1:0]   pc_plus4,
   output logic              exc_misalign,
   output logic [XLEN-1:0]   exc_tval,
   output logic              halted,
   output logic [CNT_W-1:0]  upd_count
);

   state_t          state;
   logic [XLEN-1:0] target;
   logic            misaligned;

   pc_target_calc #(
      .XLEN   (XLEN),
      .IALIGN (IALIGN)
   ) u_calc (
      .sel        (sel),
      .pc_current (pc_current),
      .imm        (imm),
      .base       (base),
      .mtvec      (mtvec),
      .mepc       (mepc),
      .target     (target),
      .misaligned (misaligned)
   );

   assign pc_plus4 = pc_current + XLEN'(4);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_RUN;
         halted       <= 1'b0;
         pc_current   <= RESET_VECTOR;
         pc_old       <= RESET_VECTOR;
         upd_count    <= '0;
         exc_misalign <= 1'b0;
         exc_tval     <= '0;
      end else begin
         exc_misalign <= 1'b0;
         case (state)
            ST_RUN: begin
               if (en && sel_is_legal(sel)) begin
                  if (misaligned) begin
                     exc_misalign <= 1'b1;
                     exc_tval     <= target;
                  end else begin
                     pc_old     <= pc_current;
                     pc_current <= target;
                     upd_count  <= upd_count + CNT_W'(1);
                  end
               end
               // An update accepted in the same cycle still completes.
               if (halt_req) begin
                  state  <= ST_HALTED;
                  halted <= 1'b1;
               end
            end
            ST_HALTED: begin
               if (resume_req && !halt_req) begin
                  state  <= ST_RUN;
                  halted <= 1'b0;
               end
            end
            default: begin
               state  <= ST_RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, PC/address width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter IALIGN, default 32, instruction alignment in bits; legal values 16 or 32.
REQ-004 Parameter CNT_W, default 32, width of update counter.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high. Ports: clk input 1 clock; rst input 1 synchronous active-high reset.
REQ-006 en input 1: update request; PC changes only on a cycle with en=1.
REQ-007 sel input 3: next-PC source; SEQ=0, BRANCH=1, JALR=2, TRAP=3, MRET=4; codes 5-7 reserved.
REQ-008 imm input XLEN: sign-extended immediate offset.
REQ-009 base input XLEN: rs1 value for JALR.
REQ-010 mtvec input XLEN: trap vector. mepc input XLEN: trap return address.
REQ-011 halt_req input 1: request to halt. resume_req input 1: request to resume.
REQ-012 pc_current output XLEN: PC of current instruction.
REQ-013 pc_old output XLEN: PC value before the most recent update.
REQ-014 pc_plus4 output XLEN: pc_current+4, combinational.
REQ-015 exc_misalign output 1: one-cycle pulse, misaligned target rejected.
REQ-016 exc_tval output XLEN: offending target, valid with exc_misalign and held until the next pulse.
REQ-017 halted output 1: high in HALTED state.
REQ-018 upd_count output CNT_W: number of accepted PC updates.

Function
REQ-019 Target by sel:
- SEQ = pc_current+4.
- BRANCH = pc_current+imm.
- JALR = (base+imm) with bit0 cleared.
- TRAP = mtvec with bits[1:0] cleared.
- MRET = mepc with bit0 cleared, plus bit1 cleared when IALIGN=32.
REQ-020 All additions are modulo 2^XLEN; wrap-around is silent and is not an exception.
REQ-021 A target is misaligned when IALIGN=32 and bit1 is 1; with IALIGN=16 no target is misaligned after the forced clears.
REQ-022 Accepted update: state RUN, en=1, sel legal, target aligned. On the next edge pc_current<=target, pc_old<=pc_current, and upd_count increments with wrap.
REQ-023 Misaligned BRANCH/JALR with en=1 in RUN: pc_current, pc_old and upd_count hold; exc_misalign=1 on the next cycle; exc_tval<=target.
REQ-024 Reserved sel with en=1: no update, no exception.
REQ-025 en=0: all registers hold and exc_misalign=0.
REQ-026 State machine:
- RUN->HALTED on halt_req.
- HALTED->RUN on resume_req with halt_req=0.
- Otherwise the state holds.
REQ-027 In HALTED, en is ignored: no update and no exception.
REQ-028 halt_req and an accepted update in the same RUN cycle: the update is performed and the state becomes HALTED.
REQ-029 resume_req in RUN is ignored. A resumed unit accepts en from the first RUN cycle.
REQ-030 Update latency is one edge. pc_current is a register output with no combinational path from en or sel.

Reset
REQ-031 On rst at a clock edge:
- pc_current=RESET_VECTOR, pc_old=RESET_VECTOR.
- upd_count=0, exc_misalign=0, exc_tval=0.
- State RUN, halted=0.
REQ-032 rst has priority over en, halt_req and resume_req, and aborts any pending exception pulse.

Structure
REQ-033 Package pc_pkg holds the sel encodings (SEL_SEQ..SEL_MRET) and the state encoding (ST_RUN, ST_HALTED).
REQ-034 Sub-module pc_target_calc computes target and misaligned combinationally from sel, pc_current, imm, base, mtvec and mepc. pc_unit holds all registers and the FSM.
REQ-035 No initial blocks; reset alone defines the power-up state.

Verification
REQ-036 Reset, then en=1 sel=SEQ for 3 cycles -> pc_current 0,4,8,12; pc_old 8 after the third update; upd_count=3.
REQ-037 pc_current=0x100, sel=BRANCH, imm=0xFFFFFFF0, en=1 -> pc_current=0xF0, pc_old=0x100. Separately, pc_current=0, imm=0xFFFFFFFC -> pc_current=0xFFFFFFFC (wrap).
REQ-038 sel=JALR, base=0x203, imm=0, en=1 -> pc_current=0x202 is rejected (bit1 set): exc_misalign pulses 1 cycle, exc_tval=0x202, PC unchanged. Repeat with IALIGN=16 -> pc_current=0x202.
REQ-039 halt_req together with en=1 sel=SEQ at PC=0x10 -> PC=0x14 and halted=1. Then en=1 for 5 cycles -> PC stays 0x14. Then resume_req -> halted=0, and the next en moves PC to 0x18.
REQ-040 sel=TRAP, mtvec=0x80000003 -> PC=0x80000000. Then sel=MRET, mepc=0x1236 -> PC=0x1234.
REQ-041 rst asserted during HALTED with en=1 -> next cycle PC=RESET_VECTOR, halted=0, upd_count=0.
